// File: rtl/vga_pkg.sv
// vga_pkg: mode codes, mode-byte field indices and helpers shared by the pattern path
package vga_pkg;
  localparam logic [2:0] MODE_PASS = 3'd0;
  localparam logic [2:0] MODE_1 = 3'd1;
  localparam logic [2:0] MODE_2 = 3'd2;
  localparam logic [2:0] MODE_3 = 3'd3;
  localparam logic [2:0] MODE_4 = 3'd4;
  localparam logic [2:0] MODE_5 = 3'd5;
  localparam logic [2:0] MODE_6 = 3'd6;
  localparam logic [2:0] MODE_7 = 3'd7;
  localparam logic [2:0] MODE_AUTO = MODE_7;
  localparam int TIMING_BIT = 7;
  localparam int MODE_MSB = 6;
  localparam int MODE_LSB = 4;
  function automatic logic [2:0] next_auto_mode(input logic [2:0] m);
    return m == MODE_1 ? MODE_2 : m == MODE_2 ? MODE_4 : m == MODE_4 ? MODE_5 :
           m == MODE_5 ? MODE_6 : MODE_1;
  endfunction
  // the auto request code is shown as mode 1, the first mode of the cycle
  function automatic logic [7:0] apply_cfg(input logic [7:0] b);
    return {b[TIMING_BIT], b[MODE_MSB:MODE_LSB] == MODE_AUTO ? MODE_1 : b[MODE_MSB:MODE_LSB], b[3:0]};
  endfunction
  function automatic logic is_auto(input logic [7:0] b);
    return b[MODE_MSB:MODE_LSB] == MODE_AUTO;
  endfunction
endpackage

// File: rtl/frame_dwell_counter.sv
// frame_dwell_counter: counts frames a mode has been shown, flags the last one
//   clk, rst_n (sync, active-low), clr (hold at 0), en (frame_end step), tc (count at DWELL_FRAMES-1)
module frame_dwell_counter #(
  parameter int DWELL_FRAMES = 64,
  parameter int DWELL_W = 12
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [DWELL_W-1:0] count;
  assign tc = count == DWELL_W'(DWELL_FRAMES - 1);
  always_ff @(posedge clk)
    if (!rst_n || clr) count <= '0;
    else if (en) count <= tc ? '0 : count + 1'b1;
endmodule

// File: rtl/mode_scheduler.sv
// mode_scheduler: sequences the pattern mode byte from reset pads, config writes and auto-cycle
//   clk, rst_n (sync, active-low), ui_in (reset-time byte), frame_end (last-pixel pulse)
//   cfg_valid/cfg_data/cfg_ready (config write, applied at frame end)
//   mode_params (mode byte), param_update (mode_params changed), auto_active (auto-cycle running)
module mode_scheduler
  import vga_pkg::*;
#(
  parameter int DWELL_FRAMES = 64,
  parameter int DWELL_W = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  input  logic       frame_end,
  input  logic       cfg_valid,
  input  logic [7:0] cfg_data,
  output logic       cfg_ready,
  output logic [7:0] mode_params,
  output logic       param_update,
  output logic       auto_active
);
  localparam logic IDLE = 1'b0;
  localparam logic PENDING = 1'b1;
  logic state;
  logic [7:0] pending;
  logic apply, step, tc, adv;
  assign apply = state == PENDING && frame_end;
  assign step = state == IDLE && frame_end && auto_active;
  assign adv = step && tc;
  assign cfg_ready = state == IDLE;
  // dwell restarts whenever a written byte takes over, and stays at 0 in manual mode
  frame_dwell_counter #(.DWELL_FRAMES(DWELL_FRAMES), .DWELL_W(DWELL_W)) u_dwell (
    .clk(clk),
    .rst_n(rst_n),
    .clr(!auto_active || apply),
    .en(step),
    .tc(tc)
  );
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      pending <= '0;
      mode_params <= apply_cfg(ui_in);
      auto_active <= is_auto(ui_in);
      param_update <= 1'b0;
    end else begin
      param_update <= apply || adv;
      if (apply) begin
        mode_params <= apply_cfg(pending);
        auto_active <= is_auto(pending);
        state <= IDLE;
      end else if (adv) begin
        mode_params[MODE_MSB:MODE_LSB] <= next_auto_mode(mode_params[MODE_MSB:MODE_LSB]);
        if (mode_params[MODE_MSB:MODE_LSB] == MODE_6) mode_params[3:0] <= mode_params[3:0] + 4'd1;
      end
      if (state == IDLE && cfg_valid) begin
        pending <= cfg_data;
        state <= PENDING;
      end
    end
endmodule

// File: tb/tb_mode_scheduler.sv
// tb_mode_scheduler: directed self-checking bench for mode_scheduler with DWELL_FRAMES=4
module tb_mode_scheduler;
  logic clk = 1'b0;
  logic rst_n, frame_end, cfg_valid, cfg_ready, param_update, auto_active;
  logic [7:0] ui_in, cfg_data, mode_params;
  int checks = 0;
  int errors = 0;
  int pu_cnt = 0;
  logic [7:0] seq [5] = '{8'hA3, 8'hC3, 8'hD3, 8'hE3, 8'h94};
  always #5 clk = ~clk;
  mode_scheduler #(.DWELL_FRAMES(4), .DWELL_W(12)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ui_in(ui_in),
    .frame_end(frame_end),
    .cfg_valid(cfg_valid),
    .cfg_data(cfg_data),
    .cfg_ready(cfg_ready),
    .mode_params(mode_params),
    .param_update(param_update),
    .auto_active(auto_active)
  );
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (param_update) pu_cnt++;
    end
  endtask
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic frame();
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
  endtask
  task automatic write(input logic [7:0] b);
    cfg_valid = 1'b1;
    cfg_data = b;
    tick();
    cfg_valid = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0;
    ui_in = 8'h1A;
    frame_end = 1'b0;
    cfg_valid = 1'b0;
    cfg_data = 8'h00;
    tick(2);
    rst_n = 1'b1;
    pu_cnt = 0;
    chk("rst_mp", mode_params, 8'h1A);
    chk("rst_auto", auto_active, 0);
    chk("rst_ready", cfg_ready, 1);
    chk("rst_pu", param_update, 0);
    for (int i = 0; i < 3; i++) begin
      frame();
      chk("man_frame_mp", mode_params, 8'h1A);
      tick(2);
    end
    chk("man_frame_auto", auto_active, 0);
    chk("man_frame_ready", cfg_ready, 1);
    chk("man_frame_pucnt", 8'(pu_cnt), 0);
    write(8'h25);
    chk("cfg_ready_low", cfg_ready, 0);
    chk("cfg_hold_mp", mode_params, 8'h1A);
    tick(3);
    chk("cfg_hold_mp2", mode_params, 8'h1A);
    frame();
    chk("cfg_apply_mp", mode_params, 8'h25);
    chk("cfg_apply_pu", param_update, 1);
    chk("cfg_apply_ready", cfg_ready, 1);
    tick();
    chk("cfg_pu_once", param_update, 0);
    chk("cfg_pucnt", 8'(pu_cnt), 1);
    rst_n = 1'b0;
    ui_in = 8'hF3;
    tick();
    rst_n = 1'b1;
    pu_cnt = 0;
    chk("auto_rst_mp", mode_params, 8'h93);
    chk("auto_rst_auto", auto_active, 1);
    for (int s = 0; s < 5; s++) begin
      for (int f = 0; f < 3; f++) begin
        frame();
        tick();
      end
      chk("auto_dwell_hold", mode_params, s == 0 ? 8'h93 : seq[s-1]);
      frame();
      chk("auto_step_mp", mode_params, seq[s]);
      chk("auto_step_pu", param_update, 1);
      tick();
    end
    chk("auto_pucnt", 8'(pu_cnt), 5);
    for (int f = 0; f < 3; f++) begin
      frame();
      tick();
    end
    write(8'h40);
    frame();
    chk("ovr_mp", mode_params, 8'h40);
    chk("ovr_auto", auto_active, 0);
    chk("ovr_pu", param_update, 1);
    for (int f = 0; f < 4; f++) begin
      tick();
      frame();
    end
    chk("ovr_manual_mp", mode_params, 8'h40);
    write(8'h7F);
    frame();
    chk("reauto_mp", mode_params, 8'h1F);
    chk("reauto_auto", auto_active, 1);
    for (int f = 0; f < 3; f++) begin
      tick();
      frame();
    end
    chk("reauto_dwell0", mode_params, 8'h1F);
    tick();
    frame();
    chk("reauto_step", mode_params, 8'h2F);
    write(8'h30);
    frame();
    chk("to_manual_mp", mode_params, 8'h30);
    tick();
    cfg_valid = 1'b1;
    cfg_data = 8'h52;
    frame_end = 1'b1;
    tick();
    cfg_valid = 1'b0;
    frame_end = 1'b0;
    chk("same_cyc_mp", mode_params, 8'h30);
    chk("same_cyc_ready", cfg_ready, 0);
    chk("same_cyc_pu", param_update, 0);
    tick();
    write(8'h66);
    chk("ignored_ready", cfg_ready, 0);
    frame();
    chk("same_cyc_apply", mode_params, 8'h52);
    chk("same_cyc_apply_pu", param_update, 1);
    tick();
    write(8'h33);
    chk("rstp_ready", cfg_ready, 0);
    rst_n = 1'b0;
    ui_in = 8'h02;
    tick();
    rst_n = 1'b1;
    chk("rstp_mp", mode_params, 8'h02);
    chk("rstp_ready2", cfg_ready, 1);
    chk("rstp_auto", auto_active, 0);
    tick();
    frame();
    chk("rstp_frame_mp", mode_params, 8'h02);
    chk("rstp_frame_pu", param_update, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
